fpu_issue_controller: RTL and testbench

FPU_ISSUE_CONTROLLER -- requirements
Module: fpu_issue_controller

---
 rtl/fpu_issue_controller_pkg.sv | 14 +
 rtl/fpu_timeout_counter.sv | 31 +++
 rtl/fpu_issue_controller.sv | 118 +++++++++++
 tb/tb_fpu_issue_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_controller_pkg.sv
// Shared definitions for the fixed-point unit issue path: operation codes
// and response-counter sizing.
package fpu_issue_controller_pkg;

   typedef enum logic [1:0] {
      FPU_ADD  = 2'd0,
      FPU_SUB  = 2'd1,
      FPU_MUL  = 2'd2,
      FPU_SQRT = 2'd3
   } fpu_op_e;

   localparam int OP_COUNT_W = 16;

endpackage

// File: rtl/fpu_timeout_counter.sv
// Counts WAIT cycles without a result; expired flags the last permitted cycle.
module fpu_timeout_counter
   import fpu_issue_controller_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Holds at LAST so a stray enable after expiry cannot wrap back to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != LAST))
         count <= count + CW'(1);
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/fpu_issue_controller.sv
// Issues one command at a time to the fixed-point unit, waits for its result
// (or a timeout), and returns a single response to the requester.
module fpu_issue_controller
   import fpu_issue_controller_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [WIDTH-1:0]      cmd_a,
   input  logic [WIDTH-1:0]      cmd_b,
   output logic [WIDTH-1:0]      fpu_operand_1,
   output logic [WIDTH-1:0]      fpu_operand_2,
   output logic [1:0]            fpu_operation,
   output logic                  fpu_request,
   input  logic [WIDTH-1:0]      fpu_result,
   input  logic                  fpu_ready,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_error,
   input  logic                  rsp_ready,
   output logic [OP_COUNT_W-1:0] op_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = S_IDLE,
      ISSUE = S_ISSUE,
      WAIT  = S_WAIT,
      RESP  = S_RESP
   } state_e;

   state_e state;
   logic   tmo_clear;
   logic   tmo_enable;
   logic   tmo_expired;

   function automatic logic [OP_COUNT_W-1:0] sat_inc(input logic [OP_COUNT_W-1:0] v);
      return (v == '1) ? v : v + OP_COUNT_W'(1);
   endfunction

   assign tmo_clear  = (state == ISSUE);
   assign tmo_enable = (state == WAIT) && !fpu_ready;

   fpu_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cmd_ready     <= 1'b1;
         fpu_request   <= 1'b0;
         fpu_operation <= FPU_ADD;
         fpu_operand_1 <= '0;
         fpu_operand_2 <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_error     <= 1'b0;
         op_count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  fpu_operation <= cmd_op;
                  fpu_operand_1 <= cmd_a;
                  fpu_operand_2 <= cmd_b;
                  fpu_request   <= 1'b1;
                  cmd_ready     <= 1'b0;
                  state         <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            // A result arriving on the timeout cycle still wins.
            WAIT: begin
               if (fpu_ready) begin
                  rsp_data    <= fpu_result;
                  rsp_error   <= 1'b0;
                  rsp_valid   <= 1'b1;
                  fpu_request <= 1'b0;
                  state       <= RESP;
               end else if (tmo_expired) begin
                  rsp_data    <= '0;
                  rsp_error   <= 1'b1;
                  rsp_valid   <= 1'b1;
                  fpu_request <= 1'b0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  if (!rsp_error)
                     op_count <= sat_inc(op_count);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Directed bench for fpu_issue_controller: transaction-level reference model,
// a scripted fixed-point unit, and per-cycle output comparison.
module tb_fpu_issue_controller;
   import fpu_issue_controller_pkg::*;

   localparam int W   = 32;
   localparam int TMO = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'd0;
   logic [W-1:0]  cmd_a = '0, cmd_b = '0;
   logic [W-1:0]  fpu_operand_1, fpu_operand_2;
   logic [1:0]    fpu_operation;
   logic          fpu_request;
   logic [W-1:0]  fpu_result = '0;
   logic          fpu_ready = 1'b0;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          rsp_error;
   logic          rsp_ready = 1'b0;
   logic [15:0]   op_count;

   fpu_issue_controller #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
      .fpu_operation(fpu_operation), .fpu_request(fpu_request),
      .fpu_result(fpu_result), .fpu_ready(fpu_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .rsp_ready(rsp_ready), .op_count(op_count)
   );

   always #5 clk = ~clk;

   int passes = 0;
   int total  = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else
         passes++;
   endtask

   always @(posedge clk) cyc++;

   // Scripted fixed-point unit: ready after dly request cycles (level) or only then (pulse).
   bit          fpu_pulse = 1'b0;
   int          fpu_dly = 0;
   logic [W-1:0] sqrt_val = '0;
   int          rc = 0;
   int          last_nreq = 0;

   function automatic logic [W-1:0] fx_result(input logic [1:0] op, input logic [W-1:0] a, b);
      longint unsigned p;
      case (op)
         FPU_ADD: return a + b;
         FPU_SUB: return a - b;
         FPU_MUL: begin p = longint'(a) * longint'(b); return W'(p >> 10); end
         default: return sqrt_val;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         rc = 0; fpu_ready = 1'b0; fpu_result = 32'hDEADBEEF;
      end else if (fpu_request) begin
         rc++;
         if (fpu_dly < 0) fpu_ready = 1'b0;
         else if (fpu_pulse) fpu_ready = (rc == fpu_dly + 1);
         else fpu_ready = (rc >= fpu_dly + 1);
         fpu_result = fpu_ready ? fx_result(fpu_operation, fpu_operand_1, fpu_operand_2) : 32'hDEADBEEF;
      end else begin
         if (rc != 0) last_nreq = rc;
         rc = 0; fpu_ready = 1'b0; fpu_result = 32'hDEADBEEF;
      end
   end

   // Reference model: one outstanding transaction, tracked by WAIT-cycle number.
   bit          m_busy, m_resp, m_err;
   int          m_age;
   logic [1:0]  m_op;
   logic [W-1:0] m_a, m_b, m_data;
   logic [15:0] m_ops;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_resp = 0; m_err = 0; m_age = 0; m_ops = 0; m_data = 0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy = 1; m_age = 0; m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
         end
      end else if (!m_resp) begin
         if (m_age == 0) m_age = 1;
         else if (fpu_ready) begin m_resp = 1; m_data = fpu_result; m_err = 0; end
         else if (m_age == TMO) begin m_resp = 1; m_data = 0; m_err = 1; end
         else m_age++;
      end else if (rsp_ready) begin
         m_busy = 0; m_resp = 0;
         if (!m_err && m_ops != 16'hFFFF) m_ops++;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("cmd_ready", cmd_ready, !m_busy);
         chk("fpu_request", fpu_request, m_busy && !m_resp);
         chk("rsp_valid", rsp_valid, m_resp);
         chk("op_count", op_count, m_ops);
         if (m_busy && !m_resp) begin
            chk("fpu_operation", fpu_operation, m_op);
            chk("fpu_operand_1", fpu_operand_1, m_a);
            chk("fpu_operand_2", fpu_operand_2, m_b);
         end
         if (m_resp) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_error", rsp_error, m_err);
         end
      end
   end

   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] a, b, input bit pulse,
                          input int dly, input int hold, input bit keep,
                          output int lat, output logic [W-1:0] data, output logic err);
      int t0, n;
      bit got;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      fpu_pulse = pulse; fpu_dly = dly;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept_ready", cmd_ready, 1'b1);
      t0 = cyc;
      @(negedge clk);
      if (keep) cmd_a = a + 1; else cmd_valid = 1'b0;
      got = 0; n = 0;
      while (!got && n < 200) begin
         if (rsp_valid) got = 1;
         else begin @(negedge clk); n++; end
      end
      chk("rsp_seen", got, 1'b1);
      lat = cyc - t0; data = rsp_data; err = rsp_error;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_data", rsp_data, data);
         chk("hold_cmd_ready", cmd_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 1'b0);
   endtask

   int          lat;
   logic [W-1:0] d;
   logic        e;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_fpu_request", fpu_request, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_rsp_error", rsp_error, 1'b0);
      chk("rst_op_count", op_count, 16'h0);
      chk("rst_fpu_operation", fpu_operation, 2'd0);
      chk("rst_operand_1", fpu_operand_1, 32'h0);

      run_cmd(FPU_ADD, 32'h400, 32'h800, 0, 0, 0, 0, lat, d, e);
      chk("add_latency", lat, 3);
      chk("add_data", d, 32'h00000C00);
      chk("add_error", e, 1'b0);
      chk("add_nreq", last_nreq, 2);
      chk("add_op_count", op_count, 16'd1);

      run_cmd(FPU_SUB, 32'h1000, 32'h400, 0, 5, 0, 0, lat, d, e);
      chk("sub_data", d, 32'h00000C00);
      chk("sub_latency", lat, 7);
      chk("sub_op_count", op_count, 16'd2);

      run_cmd(FPU_MUL, 32'h800, 32'hC00, 0, 0, 0, 0, lat, d, e);
      chk("mul_data", d, 32'h00001800);
      chk("mul_op_count", op_count, 16'd3);

      sqrt_val = 32'h800;
      run_cmd(FPU_SQRT, 32'h1000, 32'h0, 1, 21, 0, 0, lat, d, e);
      chk("sqrt_data", d, 32'h00000800);
      chk("sqrt_nreq", last_nreq, 22);
      chk("sqrt_op_count", op_count, 16'd4);

      run_cmd(FPU_ADD, 32'h1, 32'h1, 0, -1, 0, 0, lat, d, e);
      chk("tmo_error", e, 1'b1);
      chk("tmo_data", d, 32'h0);
      chk("tmo_nreq", last_nreq, 65);
      chk("tmo_op_count", op_count, 16'd4);

      run_cmd(FPU_ADD, 32'h2, 32'h2, 1, 0, 0, 0, lat, d, e);
      chk("issue_ready_ignored_err", e, 1'b1);
      chk("issue_ready_ignored_nreq", last_nreq, 65);

      run_cmd(FPU_SUB, 32'h5, 32'h7, 1, 64, 0, 0, lat, d, e);
      chk("edge_data", d, 32'hFFFFFFFE);
      chk("edge_error", e, 1'b0);
      chk("edge_nreq", last_nreq, 65);
      chk("edge_op_count", op_count, 16'd5);

      run_cmd(FPU_ADD, 32'h1, 32'h2, 0, 0, 5, 1, lat, d, e);
      chk("bp_data", d, 32'h3);
      run_cmd(FPU_MUL, 32'h400, 32'h400, 0, 0, 0, 0, lat, d, e);
      chk("bp_next_latency", lat, 3);
      chk("bp_next_data", d, 32'h400);
      chk("bp_op_count", op_count, 16'd7);

      cmd_op = FPU_ADD; cmd_a = 32'h10; cmd_b = 32'h20; cmd_valid = 1'b1; fpu_dly = -1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_reset_request", fpu_request, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_rst_request", fpu_request, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      chk("mid_rst_op_count", op_count, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (rsp_valid) chk("no_rsp_after_reset", rsp_valid, 1'b0);
      end
      chk("post_rst_cmd_ready", cmd_ready, 1'b1);

      fpu_dly = 0;
      run_cmd(FPU_ADD, 32'h400, 32'h800, 0, 0, 0, 0, lat, d, e);
      chk("recover_data", d, 32'h00000C00);
      chk("recover_op_count", op_count, 16'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
